// File: rtl/apb2axi_pkg.sv
// Shared definitions for the APB4 to AXI4-Lite bridge: FSM states and
// AXI response codes.
package apb2axi_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        W_REQ    = 3'd1,
        W_RESP   = 3'd2,
        R_REQ    = 3'd3,
        R_RESP   = 3'd4,
        COMPLETE = 3'd5
    } state_t;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] EXOKAY = 2'b01;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    // OKAY and EXOKAY are success; SLVERR and DECERR are reported as errors.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/apb2axi_lite_bridge.sv
// APB4 slave to AXI4-Lite master bridge. Each APB transfer is turned into
// exactly one AXI4-Lite write or read; PREADY is withheld until the AXI
// response has returned. All outputs are registered.
module apb2axi_lite_bridge
    import apb2axi_pkg::*;
#(
    parameter  int ADDR_W      = 32,
    parameter  int DATA_W      = 32,
    parameter  int ALIGN_CHECK = 1,
    localparam int STRB_W      = DATA_W / 8
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    // APB slave side
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [DATA_W-1:0] PWDATA,
    input  logic [STRB_W-1:0] PSTRB,
    input  logic [2:0]        PPROT,
    input  logic              PWRITE,
    input  logic              PSEL,
    input  logic              PENABLE,
    output logic [DATA_W-1:0] PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    // AXI4-Lite write address channel
    output logic [ADDR_W-1:0] AWADDR,
    output logic [2:0]        AWPROT,
    output logic              AWVALID,
    input  logic              AWREADY,
    // AXI4-Lite write data channel
    output logic [DATA_W-1:0] WDATA,
    output logic [STRB_W-1:0] WSTRB,
    output logic              WVALID,
    input  logic              WREADY,
    // AXI4-Lite write response channel
    input  logic [1:0]        BRESP,
    input  logic              BVALID,
    output logic              BREADY,
    // AXI4-Lite read address channel
    output logic [ADDR_W-1:0] ARADDR,
    output logic [2:0]        ARPROT,
    output logic              ARVALID,
    input  logic              ARREADY,
    // AXI4-Lite read data channel
    input  logic [DATA_W-1:0] RDATA,
    input  logic [1:0]        RRESP,
    input  logic              RVALID,
    output logic              RREADY
);

    localparam int LSB_W = $clog2(STRB_W);

    state_t state_q;

    logic setup;
    logic misaligned;
    logic aw_fin;
    logic w_fin;

    // Setup phase decode, alignment test and per-channel write completion.
    // A channel counts as finished once its VALID has already dropped or
    // its handshake happens on this edge, so AW and W may finish in any order.
    always_comb begin
        setup      = PSEL && !PENABLE;
        misaligned = (ALIGN_CHECK != 0) && (PADDR[LSB_W-1:0] != '0);
        aw_fin     = !AWVALID || AWREADY;
        w_fin      = !WVALID  || WREADY;
    end

    // Transfer sequencing: owns the state and every handshake/response output.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_q <= IDLE;
            AWVALID <= 1'b0;
            WVALID  <= 1'b0;
            BREADY  <= 1'b0;
            ARVALID <= 1'b0;
            RREADY  <= 1'b0;
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
        end else begin
            PREADY  <= 1'b0;
            PSLVERR <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (setup) begin
                        if (misaligned) begin
                            state_q <= COMPLETE;
                            PREADY  <= 1'b1;
                            PSLVERR <= 1'b1;
                        end else if (PWRITE) begin
                            state_q <= W_REQ;
                            AWVALID <= 1'b1;
                            WVALID  <= 1'b1;
                        end else begin
                            state_q <= R_REQ;
                            ARVALID <= 1'b1;
                        end
                    end
                end
                W_REQ: begin
                    if (AWREADY) AWVALID <= 1'b0;
                    if (WREADY)  WVALID  <= 1'b0;
                    if (aw_fin && w_fin) begin
                        state_q <= W_RESP;
                        BREADY  <= 1'b1;
                    end
                end
                W_RESP: begin
                    if (BVALID) begin
                        state_q <= COMPLETE;
                        BREADY  <= 1'b0;
                        PREADY  <= 1'b1;
                        PSLVERR <= resp_is_err(BRESP);
                    end
                end
                R_REQ: begin
                    if (ARREADY) begin
                        state_q <= R_RESP;
                        ARVALID <= 1'b0;
                        RREADY  <= 1'b1;
                    end
                end
                R_RESP: begin
                    if (RVALID) begin
                        state_q <= COMPLETE;
                        RREADY  <= 1'b0;
                        PREADY  <= 1'b1;
                        PSLVERR <= resp_is_err(RRESP);
                    end
                end
                COMPLETE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Capture the APB request in the setup phase; held for the whole transfer.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            AWADDR <= '0;
            AWPROT <= '0;
            WDATA  <= '0;
            WSTRB  <= '0;
            ARADDR <= '0;
            ARPROT <= '0;
        end else if (state_q == IDLE && setup) begin
            AWADDR <= PADDR;
            AWPROT <= PPROT;
            WDATA  <= PWDATA;
            WSTRB  <= PSTRB;
            ARADDR <= PADDR;
            ARPROT <= PPROT;
        end
    end

    // Read data changes only on an R handshake and holds otherwise.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            PRDATA <= '0;
        end else if (state_q == R_RESP && RVALID && RREADY) begin
            PRDATA <= RDATA;
        end
    end

endmodule

// File: tb/tb_apb2axi_lite_bridge.sv
// Directed bench for apb2axi_lite_bridge. Each transfer is described by its
// slave-side delays and response; the expected per-cycle outputs are derived
// from those numbers as a timeline, and one negedge process compares them.
module tb_apb2axi_lite_bridge;

    logic        PCLK;
    logic        PRESETn;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic        PWRITE, PSEL, PENABLE;
    logic [31:0] PRDATA;
    logic        PREADY, PSLVERR;
    logic [31:0] AWADDR;
    logic [2:0]  AWPROT;
    logic        AWVALID, AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WVALID, WREADY;
    logic [1:0]  BRESP;
    logic        BVALID, BREADY;
    logic [31:0] ARADDR;
    logic [2:0]  ARPROT;
    logic        ARVALID, ARREADY;
    logic [31:0] RDATA;
    logic [1:0]  RRESP;
    logic        RVALID, RREADY;

    apb2axi_lite_bridge #(.ADDR_W(32), .DATA_W(32), .ALIGN_CHECK(1)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PWRITE(PWRITE), .PSEL(PSEL), .PENABLE(PENABLE),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    int n_vec = 0;
    int n_bad = 0;

    // expected outputs for the current cycle
    logic        e_awv, e_wv, e_bready, e_arv, e_rready, e_pready, e_perr;
    logic [31:0] e_prdata;
    logic [31:0] e_addr, e_data;
    logic [3:0]  e_strb;
    logic [2:0]  e_prot;
    int          cur_k;

    // observations made by the compare process during one transfer
    int obs_pready_k, obs_awv, obs_wv, obs_arv, obs_perr;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Single compare process: every cycle, away from the clock edge.
    always @(negedge PCLK) begin
        chk("AWVALID", {63'd0, AWVALID}, {63'd0, e_awv});
        chk("WVALID",  {63'd0, WVALID},  {63'd0, e_wv});
        chk("BREADY",  {63'd0, BREADY},  {63'd0, e_bready});
        chk("ARVALID", {63'd0, ARVALID}, {63'd0, e_arv});
        chk("RREADY",  {63'd0, RREADY},  {63'd0, e_rready});
        chk("PREADY",  {63'd0, PREADY},  {63'd0, e_pready});
        chk("PSLVERR", {63'd0, PSLVERR}, {63'd0, e_perr});
        chk("PRDATA",  {32'd0, PRDATA},  {32'd0, e_prdata});
        if (e_awv) begin
            chk("AWADDR", {32'd0, AWADDR}, {32'd0, e_addr});
            chk("AWPROT", {61'd0, AWPROT}, {61'd0, e_prot});
        end
        if (e_wv) begin
            chk("WDATA", {32'd0, WDATA}, {32'd0, e_data});
            chk("WSTRB", {60'd0, WSTRB}, {60'd0, e_strb});
        end
        if (e_arv) begin
            chk("ARADDR", {32'd0, ARADDR}, {32'd0, e_addr});
            chk("ARPROT", {61'd0, ARPROT}, {61'd0, e_prot});
        end
        if (cur_k >= 0) begin
            if (PREADY === 1'b1 && obs_pready_k < 0) obs_pready_k = cur_k;
            if (PREADY === 1'b1 && PSLVERR === 1'b1) obs_perr++;
            if (AWVALID === 1'b1) obs_awv++;
            if (WVALID === 1'b1)  obs_wv++;
            if (ARVALID === 1'b1) obs_arv++;
        end
    end

    task automatic clear_exp();
        e_awv = 0; e_wv = 0; e_bready = 0; e_arv = 0; e_rready = 0;
        e_pready = 0; e_perr = 0;
    endtask

    task automatic drive_idle();
        PSEL = 0; PENABLE = 0; PWRITE = 0;
        AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 2'b00;
        ARREADY = 0; RVALID = 0; RRESP = 2'b00; RDATA = 32'hBAD0_0000;
    endtask

    // Idle cycle(s) with PSEL low, ending just after a compare point.
    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK); #1;
            drive_idle();
            clear_exp();
            cur_k = -1;
        end
        @(negedge PCLK); #1;
    endtask

    // One APB transfer. d1: AW (or AR) ready delay, d2: W ready delay,
    // d3: B (or R) response delay after the request phase ends.
    // abort_k >= 0 asserts reset during that cycle of the transfer.
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [2:0] prot,
                        input int d1, input int d2, input int d3,
                        input logic [1:0] resp, input logic [31:0] rdata, input int abort_k);
        logic mis;
        int   h, n;
        mis = (addr % 4) != 0;
        if (mis)     begin h = 0; n = 1; end
        else if (wr) begin h = 1 + ((d1 > d2) ? d1 : d2); n = h + 2 + d3; end
        else         begin h = 1 + d1; n = h + 2 + d3; end
        obs_pready_k = -1; obs_awv = 0; obs_wv = 0; obs_arv = 0; obs_perr = 0;
        e_addr = addr; e_data = data; e_strb = strb; e_prot = prot;
        for (int k = 0; k <= n; k++) begin
            @(posedge PCLK); #1;
            cur_k = k;
            // APB master
            PSEL = 1; PENABLE = (k > 0); PADDR = addr; PWDATA = data;
            PSTRB = strb; PPROT = prot; PWRITE = wr;
            // AXI slave
            AWREADY = !mis && wr && k >= 1 + d1 && k <= h;
            WREADY  = !mis && wr && k >= 1 + d2 && k <= h;
            BVALID  = !mis && wr && k == h + 1 + d3;
            BRESP   = BVALID ? resp : 2'b00;
            ARREADY = !mis && !wr && k == 1 + d1;
            RVALID  = !mis && !wr && k == h + 1 + d3;
            RRESP   = RVALID ? resp : 2'b00;
            RDATA   = RVALID ? rdata : 32'hBAD0_0000;
            // expected outputs
            e_awv    = !mis && wr && k >= 1 && k <= 1 + d1;
            e_wv     = !mis && wr && k >= 1 && k <= 1 + d2;
            e_bready = !mis && wr && k >= h + 1 && k <= h + 1 + d3;
            e_arv    = !mis && !wr && k >= 1 && k <= 1 + d1;
            e_rready = !mis && !wr && k >= h + 1 && k <= h + 1 + d3;
            e_pready = (k == n);
            e_perr   = (k == n) && (mis || resp[1]);
            if (!mis && !wr && k == n) e_prdata = rdata;
            if (k == abort_k) begin
                #2 PRESETn = 0;
                #1;
                chk("rst_AWVALID", {63'd0, AWVALID}, 64'd0);
                chk("rst_WVALID",  {63'd0, WVALID},  64'd0);
                chk("rst_PREADY",  {63'd0, PREADY},  64'd0);
                clear_exp();
                e_prdata = 32'd0;
                drive_idle();
                cur_k = -1;
                return;
            end
        end
        idle_cycles(1);
    endtask

    initial begin
        PRESETn = 0;
        PADDR = 0; PWDATA = 0; PSTRB = 0; PPROT = 0;
        drive_idle();
        clear_exp();
        e_prdata = 32'd0; e_addr = 0; e_data = 0; e_strb = 0; e_prot = 0;
        cur_k = -1;
        obs_pready_k = -1; obs_awv = 0; obs_wv = 0; obs_arv = 0; obs_perr = 0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1;
        idle_cycles(1);

        // Protocol violation in IDLE: access phase without setup is ignored.
        for (int i = 0; i < 3; i++) begin
            @(posedge PCLK); #1;
            PSEL = 1; PENABLE = 1; PWRITE = 1; PADDR = 32'h0000_0040;
        end
        idle_cycles(1);

        // Write, slave always ready, OKAY.
        xfer(1, 32'h0000_1000, 32'hCAFE_F00D, 4'hF, 3'b000, 0, 0, 0, 2'b00, 0, -1);
        chk("t1_pready_cycle", obs_pready_k, 3);
        chk("t1_awvalid_cycles", obs_awv, 1);
        chk("t1_pslverr", obs_perr, 0);

        // Read, ARREADY after 4 wait cycles.
        xfer(0, 32'h0000_2004, 0, 4'h0, 3'b010, 4, 0, 0, 2'b00, 32'h1234_5678, -1);
        chk("t2_arvalid_cycles", obs_arv, 5);
        chk("t2_pready_cycle", obs_pready_k, 7);
        chk("t2_prdata", PRDATA, 32'h1234_5678);
        chk("t2_pslverr", obs_perr, 0);

        // Write, W accepted at T1, AW at T4, B one cycle late.
        xfer(1, 32'h0000_3000, 32'h0BAD_BEEF, 4'h5, 3'b101, 3, 0, 1, 2'b00, 0, -1);
        chk("t3_wvalid_cycles", obs_wv, 1);
        chk("t3_awvalid_cycles", obs_awv, 4);
        chk("t3_pready_cycle", obs_pready_k, 7);
        chk("t3_prdata_held", PRDATA, 32'h1234_5678);

        // Error responses and EXOKAY.
        xfer(0, 32'h0000_3008, 0, 4'h0, 3'b000, 0, 0, 2, 2'b10, 32'hDEAD_BEEF, -1);
        chk("t4_slverr", obs_perr, 1);
        chk("t4_prdata", PRDATA, 32'hDEAD_BEEF);
        xfer(1, 32'h0000_400C, 32'h1111_2222, 4'h3, 3'b001, 1, 2, 0, 2'b11, 0, -1);
        chk("t5_decerr", obs_perr, 1);
        xfer(0, 32'h0000_5010, 0, 4'h0, 3'b000, 1, 0, 1, 2'b01, 32'hA5A5_5A5A, -1);
        chk("t6_exokay", obs_perr, 0);
        chk("t6_prdata", PRDATA, 32'hA5A5_5A5A);

        // Misaligned accesses: rejected with no AXI activity.
        xfer(1, 32'h0000_1002, 32'h7777_7777, 4'hF, 3'b000, 0, 0, 0, 2'b00, 0, -1);
        chk("t7_pready_cycle", obs_pready_k, 1);
        chk("t7_awvalid_cycles", obs_awv, 0);
        chk("t7_wvalid_cycles", obs_wv, 0);
        chk("t7_pslverr", obs_perr, 1);
        xfer(0, 32'h0000_2001, 0, 4'h0, 3'b000, 0, 0, 0, 2'b00, 32'h5555_5555, -1);
        chk("t8_arvalid_cycles", obs_arv, 0);
        chk("t8_prdata_held", PRDATA, 32'hA5A5_5A5A);

        // Reset while W_REQ is waiting for AWREADY.
        xfer(1, 32'h0000_6000, 32'h6666_6666, 4'hF, 3'b000, 5, 0, 0, 2'b00, 0, 2);
        chk("t9_awvalid_seen", obs_awv, 1);
        repeat (2) @(posedge PCLK);
        #1 PRESETn = 1;
        idle_cycles(1);

        // Transfers after reset release complete normally.
        xfer(1, 32'h0000_7000, 32'h0102_0304, 4'hF, 3'b000, 0, 1, 0, 2'b00, 0, -1);
        chk("t10_pready_cycle", obs_pready_k, 4);
        chk("t10_pslverr", obs_perr, 0);
        xfer(0, 32'h0000_7004, 0, 4'h0, 3'b000, 0, 0, 0, 2'b00, 32'hFEED_FACE, -1);
        chk("t11_pready_cycle", obs_pready_k, 3);
        chk("t11_prdata", PRDATA, 32'hFEED_FACE);

        idle_cycles(2);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
